// File: rtl/exc_pkg.sv
// Shared types, field widths and default trap vectors for the exception/interrupt controller.
package exc_pkg;

    typedef enum logic [1:0] {
        ST_USER   = 2'd0,
        ST_TRAP   = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_KERNEL = 2'd3
    } exc_state_e;

    localparam int unsigned IRQ_IDX_W = 4;
    localparam int unsigned CAUSE_W   = IRQ_IDX_W + 1;

    localparam logic [31:0] DEF_XADR_VEC   = 32'h8000_0008;
    localparam logic [31:0] DEF_IRQ_VEC    = 32'h8000_0004;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

    // Channel vector; 32-bit arithmetic so the result wraps mod 2^32.
    function automatic logic [31:0] irq_vector(
        input logic [31:0]          base,
        input logic [31:0]          stride,
        input logic [IRQ_IDX_W-1:0] idx
    );
        return base + ({{(32-IRQ_IDX_W){1'b0}}, idx} * stride);
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt channels.
module exc_prio_enc
    import exc_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    output logic                 valid_o,
    output logic [IRQ_IDX_W-1:0] idx_o
);

    // Scan from the top so the last hit, the lowest index, is the one kept.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IRQ_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller beside the ID stage: pending/mask tracking, cause selection,
// trap vector, fixed-length pipeline flush and kernel-mode tracking until ERET.
module exc_irq_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned N_IRQ      = 4,
    parameter int unsigned FLUSH_CYC  = 2,
    parameter logic [31:0] XADR_VEC   = DEF_XADR_VEC,
    parameter logic [31:0] IRQ_VEC    = DEF_IRQ_VEC,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     irq_i,
    input  logic                 undef_i,
    input  logic                 id_valid_i,
    input  logic [31:0]          id_pc_i,
    input  logic                 stall_i,
    input  logic                 eret_i,
    input  logic                 mask_we_i,
    input  logic [N_IRQ-1:0]     mask_wd_i,
    input  logic [N_IRQ-1:0]     ack_i,
    output logic                 take_o,
    output logic [31:0]          vec_o,
    output logic                 flush_o,
    output logic                 ker_o,
    output logic [31:0]          epc_o,
    output logic [CAUSE_W-1:0]   cause_o,
    output logic [N_IRQ-1:0]     pend_o,
    output logic                 err_o
);

    localparam int unsigned      CNT_W    = $clog2(FLUSH_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYC - 1);

    exc_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_IRQ-1:0]     pend_q, pend_d;
    logic [N_IRQ-1:0]     mask_q, mask_d;
    logic [31:0]          vec_q, vec_d;
    logic [31:0]          epc_q, epc_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic                 err_q, err_d;

    logic [N_IRQ-1:0]     eligible;
    logic                 irq_valid;
    logic [IRQ_IDX_W-1:0] irq_idx;
    logic                 trigger;
    logic                 eret_ok;

    // Acknowledge beats a same-cycle request; the mask gates new requests only.
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
        assign pend_d[gi] = (pend_q[gi] | (irq_i[gi] & mask_q[gi])) & ~ack_i[gi];
    end

    assign mask_d   = mask_we_i ? mask_wd_i : mask_q;
    assign eligible = pend_q & mask_q;

    exc_prio_enc #(
        .N (N_IRQ)
    ) u_prio (
        .req_i   (eligible),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

    assign trigger = (state_q == ST_USER) & id_valid_i & ~stall_i & (undef_i | irq_valid);
    assign eret_ok = eret_i & id_valid_i & ~stall_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        err_d   = err_q;
        case (state_q)
            ST_USER: begin
                if (trigger) begin
                    state_d = ST_TRAP;
                    cnt_d   = CNT_LOAD;
                    if (undef_i) begin
                        vec_d   = XADR_VEC;
                        epc_d   = id_pc_i + 32'd4;
                        cause_d = {1'b1, {IRQ_IDX_W{1'b0}}};
                    end else begin
                        vec_d   = irq_vector(IRQ_VEC, VEC_STRIDE, irq_idx);
                        epc_d   = id_pc_i;
                        cause_d = {1'b0, irq_idx};
                    end
                end
            end
            // cnt_q counts the flush cycles still owed after the current one.
            ST_TRAP, ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_KERNEL;
                end else begin
                    state_d = ST_FLUSH;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            ST_KERNEL: begin
                if (undef_i & id_valid_i) begin
                    err_d = 1'b1;
                end
                if (eret_ok) begin
                    state_d = ST_USER;
                end
            end
            default: begin
                state_d = ST_USER;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_USER;
            cnt_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '1;
            vec_q   <= '0;
            epc_q   <= '0;
            cause_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            vec_q   <= vec_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            err_q   <= err_d;
        end
    end

    assign take_o  = (state_q == ST_TRAP);
    assign flush_o = (state_q == ST_TRAP) | (state_q == ST_FLUSH);
    assign ker_o   = (state_q != ST_USER);
    assign vec_o   = vec_q;
    assign epc_o   = epc_q;
    assign cause_o = cause_q;
    assign pend_o  = pend_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Bench for exc_irq_ctrl: directed vector table, reset-in-flush sequence and randomized traffic vs a model.
module tb_exc_irq_ctrl;

    localparam int          N  = 4;
    localparam int          FC = 2;
    localparam logic [31:0] XV = 32'h8000_0008;
    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] VS = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  irq_i, mask_wd_i, ack_i;
    logic        undef_i, id_valid_i, stall_i, eret_i, mask_we_i;
    logic [31:0] id_pc_i;
    logic        take_o, flush_o, ker_o, err_o;
    logic [31:0] vec_o, epc_o;
    logic [4:0]  cause_o;
    logic [3:0]  pend_o;

    always #5 clk = ~clk;

    exc_irq_ctrl #(
        .N_IRQ(N), .FLUSH_CYC(FC), .XADR_VEC(XV), .IRQ_VEC(IV), .VEC_STRIDE(VS)
    ) dut (
        .clk(clk), .reset(reset), .irq_i(irq_i), .undef_i(undef_i), .id_valid_i(id_valid_i),
        .id_pc_i(id_pc_i), .stall_i(stall_i), .eret_i(eret_i), .mask_we_i(mask_we_i),
        .mask_wd_i(mask_wd_i), .ack_i(ack_i), .take_o(take_o), .vec_o(vec_o), .flush_o(flush_o),
        .ker_o(ker_o), .epc_o(epc_o), .cause_o(cause_o), .pend_o(pend_o), .err_o(err_o)
    );

    typedef struct packed {
        logic        take;
        logic [31:0] vec;
        logic        flush;
        logic        ker;
        logic [31:0] epc;
        logic [4:0]  cause;
        logic [3:0]  pend;
        logic        err;
    } outs_t;

    typedef struct {
        logic [3:0]  irq;
        logic        undef, valid;
        logic [31:0] pc;
        logic        stall, eret, mwe;
        logic [3:0]  mwd, ack;
        outs_t       exp;
    } row_t;

    row_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: kernel flag plus a countdown of flush cycles left.
    bit        m_ker, m_take, m_err;
    int        m_drain;
    bit [3:0]  m_pend, m_mask;
    bit [31:0] m_vec, m_epc;
    bit [4:0]  m_cause;

    function automatic outs_t dut_outs();
        outs_t o;
        o.take = take_o; o.vec = vec_o; o.flush = flush_o; o.ker = ker_o;
        o.epc = epc_o; o.cause = cause_o; o.pend = pend_o; o.err = err_o;
        return o;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o.take = m_take; o.vec = m_vec; o.flush = (m_drain > 0); o.ker = m_ker;
        o.epc = m_epc; o.cause = m_cause; o.pend = m_pend; o.err = m_err;
        return o;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("take=%0b vec=%h flush=%0b ker=%0b epc=%h cause=%h pend=%b err=%0b",
                         o.take, o.vec, o.flush, o.ker, o.epc, o.cause, o.pend, o.err);
    endfunction

    task automatic model_reset();
        m_ker = 0; m_take = 0; m_err = 0; m_drain = 0;
        m_pend = 4'h0; m_mask = 4'hF; m_vec = 0; m_epc = 0; m_cause = 0;
    endtask

    task automatic model_step();
        bit [3:0] elig;
        int       k;
        bit       trig;
        if (reset) begin
            model_reset();
            return;
        end
        elig = m_pend & m_mask;
        k = -1;
        for (int i = N - 1; i >= 0; i--) if (elig[i]) k = i;
        trig   = !m_ker && id_valid_i && !stall_i && (undef_i || k >= 0);
        m_take = trig;
        if (trig) begin
            m_ker   = 1;
            m_drain = FC;
            if (undef_i) begin
                m_vec = XV; m_epc = id_pc_i + 32'd4; m_cause = 5'h10;
            end else begin
                m_vec = IV + 32'(k) * VS; m_epc = id_pc_i; m_cause = 5'(k);
            end
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (m_ker) begin
            if (undef_i && id_valid_i) m_err = 1;
            if (eret_i && id_valid_i && !stall_i) m_ker = 0;
        end
        m_pend = (m_pend | (irq_i & m_mask)) & ~ack_i;
        if (mask_we_i) m_mask = mask_wd_i;
    endtask

    task automatic idle();
        irq_i = 0; undef_i = 0; id_valid_i = 0; id_pc_i = 0; stall_i = 0;
        eret_i = 0; mask_we_i = 0; mask_wd_i = 0; ack_i = 0;
    endtask

    task automatic step(input string tag);
        outs_t got, exp;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        got = dut_outs();
        exp = model_outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got {%s} required {%s}", tag, cyc, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_exp(input string tag, input outs_t exp);
        outs_t got;
        got = dut_outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got {%s} required {%s}", tag, fmt(got), fmt(exp));
        end
    endtask

    task automatic add(input int irq, input int u, input int v, input logic [31:0] pc, input int st,
                       input int er, input int mwe, input int mwd, input int ack,
                       input int tk, input logic [31:0] vec, input int fl, input int kr,
                       input logic [31:0] epc, input int cause, input int pend, input int err);
        row_t r;
        r.irq = 4'(irq); r.undef = 1'(u); r.valid = 1'(v); r.pc = pc; r.stall = 1'(st);
        r.eret = 1'(er); r.mwe = 1'(mwe); r.mwd = 4'(mwd); r.ack = 4'(ack);
        r.exp.take = 1'(tk); r.exp.vec = vec; r.exp.flush = 1'(fl); r.exp.ker = 1'(kr);
        r.exp.epc = epc; r.exp.cause = 5'(cause); r.exp.pend = 4'(pend); r.exp.err = 1'(err);
        tbl.push_back(r);
    endtask

    initial begin
        idle();
        reset = 1;
        step("reset");
        step("reset");
        reset = 0;
        check_exp("reset_state", '0);

        //  irq  ud vl pc            st er mwe mwd ack | tk vec           fl kr epc           cause pend err
        add(4'h4, 0, 0, 32'h0,        0, 0, 0, 0, 0,    0, 32'h0,        0, 0, 32'h0,        5'h00, 4'h4, 0);
        add(4'h4, 0, 1, 32'h00400010, 0, 0, 0, 0, 0,    1, 32'h80000024, 1, 1, 32'h00400010, 5'h02, 4'h4, 0);
        add(0,    0, 1, 32'h00400014, 0, 0, 0, 0, 4'h4, 0, 32'h80000024, 1, 1, 32'h00400010, 5'h02, 4'h0, 0);
        add(0,    0, 0, 32'h0,        0, 0, 0, 0, 0,    0, 32'h80000024, 0, 1, 32'h00400010, 5'h02, 4'h0, 0);
        add(0,    0, 1, 32'h0,        0, 1, 0, 0, 0,    0, 32'h80000024, 0, 0, 32'h00400010, 5'h02, 4'h0, 0);
        add(4'h3, 0, 0, 32'h0,        0, 0, 0, 0, 0,    0, 32'h80000024, 0, 0, 32'h00400010, 5'h02, 4'h3, 0);
        add(4'h3, 1, 1, 32'h00400020, 0, 0, 0, 0, 0,    1, 32'h80000008, 1, 1, 32'h00400024, 5'h10, 4'h3, 0);
        add(0,    0, 0, 32'h0,        0, 0, 0, 0, 0,    0, 32'h80000008, 1, 1, 32'h00400024, 5'h10, 4'h3, 0);
        add(0,    0, 0, 32'h0,        0, 0, 0, 0, 0,    0, 32'h80000008, 0, 1, 32'h00400024, 5'h10, 4'h3, 0);
        add(4'h8, 0, 0, 32'h0,        0, 0, 0, 0, 0,    0, 32'h80000008, 0, 1, 32'h00400024, 5'h10, 4'hB, 0);
        add(0,    0, 1, 32'h0,        0, 1, 0, 0, 4'h3, 0, 32'h80000008, 0, 0, 32'h00400024, 5'h10, 4'h8, 0);
        add(0,    0, 1, 32'h00400100, 0, 0, 0, 0, 0,    1, 32'h80000034, 1, 1, 32'h00400100, 5'h03, 4'h8, 0);
        add(0,    0, 0, 32'h0,        0, 0, 0, 0, 4'h8, 0, 32'h80000034, 1, 1, 32'h00400100, 5'h03, 4'h0, 0);
        add(0,    0, 0, 32'h0,        0, 0, 0, 0, 0,    0, 32'h80000034, 0, 1, 32'h00400100, 5'h03, 4'h0, 0);
        add(0,    0, 1, 32'h0,        0, 1, 0, 0, 0,    0, 32'h80000034, 0, 0, 32'h00400100, 5'h03, 4'h0, 0);
        add(0,    0, 0, 32'h0,        0, 0, 1, 4'hE, 0, 0, 32'h80000034, 0, 0, 32'h00400100, 5'h03, 4'h0, 0);
        add(4'h1, 0, 1, 32'h00400200, 0, 0, 0, 0, 0,    0, 32'h80000034, 0, 0, 32'h00400100, 5'h03, 4'h0, 0);
        add(4'h1, 0, 1, 32'h00400200, 0, 0, 0, 0, 0,    0, 32'h80000034, 0, 0, 32'h00400100, 5'h03, 4'h0, 0);
        add(4'h1, 0, 1, 32'h00400200, 0, 0, 1, 4'hF, 0, 0, 32'h80000034, 0, 0, 32'h00400100, 5'h03, 4'h0, 0);
        add(4'h1, 0, 1, 32'h00400200, 0, 0, 0, 0, 0,    0, 32'h80000034, 0, 0, 32'h00400100, 5'h03, 4'h1, 0);
        add(0,    0, 1, 32'h00400200, 0, 0, 0, 0, 0,    1, 32'h80000004, 1, 1, 32'h00400200, 5'h00, 4'h1, 0);
        add(0,    0, 0, 32'h0,        0, 0, 0, 0, 4'h1, 0, 32'h80000004, 1, 1, 32'h00400200, 5'h00, 4'h0, 0);
        add(0,    1, 1, 32'h0,        0, 0, 0, 0, 0,    0, 32'h80000004, 0, 1, 32'h00400200, 5'h00, 4'h0, 0);
        add(0,    1, 1, 32'h0,        0, 0, 0, 0, 0,    0, 32'h80000004, 0, 1, 32'h00400200, 5'h00, 4'h0, 1);
        add(0,    0, 1, 32'h0,        0, 1, 0, 0, 0,    0, 32'h80000004, 0, 0, 32'h00400200, 5'h00, 4'h0, 1);
        add(4'h4, 0, 0, 32'h0,        0, 0, 0, 0, 0,    0, 32'h80000004, 0, 0, 32'h00400200, 5'h00, 4'h4, 1);
        add(0,    0, 1, 32'h00400300, 1, 0, 0, 0, 0,    0, 32'h80000004, 0, 0, 32'h00400200, 5'h00, 4'h4, 1);
        add(0,    0, 0, 32'h00400300, 0, 0, 0, 0, 0,    0, 32'h80000004, 0, 0, 32'h00400200, 5'h00, 4'h4, 1);
        add(0,    0, 1, 32'h00400300, 0, 0, 0, 0, 0,    1, 32'h80000024, 1, 1, 32'h00400300, 5'h02, 4'h4, 1);
        add(4'h4, 0, 0, 32'h0,        0, 0, 0, 0, 4'h4, 0, 32'h80000024, 1, 1, 32'h00400300, 5'h02, 4'h0, 1);
        add(0,    0, 1, 32'h0,        0, 1, 0, 0, 0,    0, 32'h80000024, 0, 1, 32'h00400300, 5'h02, 4'h0, 1);
        add(0,    0, 1, 32'h0,        0, 1, 0, 0, 0,    0, 32'h80000024, 0, 0, 32'h00400300, 5'h02, 4'h0, 1);
        add(0,    0, 1, 32'h0,        0, 1, 0, 0, 0,    0, 32'h80000024, 0, 0, 32'h00400300, 5'h02, 4'h0, 1);

        foreach (tbl[i]) begin
            irq_i = tbl[i].irq; undef_i = tbl[i].undef; id_valid_i = tbl[i].valid;
            id_pc_i = tbl[i].pc; stall_i = tbl[i].stall; eret_i = tbl[i].eret;
            mask_we_i = tbl[i].mwe; mask_wd_i = tbl[i].mwd; ack_i = tbl[i].ack;
            step($sformatf("model_row%0d", i));
            check_exp($sformatf("row%0d", i), tbl[i].exp);
        end

        // Reset asserted while the flush window is still open.
        idle();
        irq_i = 4'h2;
        step("rf_pend");
        irq_i = 4'h0; id_valid_i = 1; id_pc_i = 32'h0040_0400;
        step("rf_take");
        checks++;
        if (take_o !== 1'b1 || vec_o !== 32'h8000_0014) begin
            errors++;
            $display("FAIL rf_take got take=%0b vec=%h required take=1 vec=80000014", take_o, vec_o);
        end
        idle();
        step("rf_flush");
        reset = 1;
        step("rf_reset");
        reset = 0;
        check_exp("reset_in_flush", '0);
        irq_i = 4'h1;
        step("rf_mask_restored");
        checks++;
        if (pend_o !== 4'h1 || ker_o !== 1'b0) begin
            errors++;
            $display("FAIL rf_mask got pend=%b ker=%0b required pend=0001 ker=0", pend_o, ker_o);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 63) == 0);
            irq_i      = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
            ack_i      = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'h0;
            undef_i    = ($urandom_range(0, 7) == 0);
            id_valid_i = ($urandom_range(0, 3) != 0);
            id_pc_i    = $urandom() & 32'hFFFF_FFFC;
            stall_i    = ($urandom_range(0, 4) == 0);
            eret_i     = ($urandom_range(0, 5) == 0);
            mask_we_i  = ($urandom_range(0, 19) == 0);
            mask_wd_i  = 4'($urandom());
            step("random");
        end
        reset = 0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
